lsu_obi_arbiter: RTL and testbench
==================================

// Module: lsu_obi_arbiter
// PURPOSE
// - Shares the single LSU data-memory OBI port between two requesters:
//   p0 = core LSU (data_req_o/data_addr_o/... side), p1 = secondary master (debug/DMA).
// - Round-robin arbitration with OBI address-phase lock.
// - FIFO of requester IDs routes each rvalid/rdata back to its issuer.
// - Sits between the load-store unit and the data bus; the core LSU sees an unchanged OBI port.
// PARAMETERS
// - MAX_OUTSTANDING  2   depth of ID FIFO = max granted-but-unanswered transactions (>=1)
// - ADDR_WIDTH       32  address width
// - DATA_WIDTH       32  data width; BE width = DATA_WIDTH/8
// PORTS (p{0,1} = one port per requester)
// - clk                   in   1      clock, all state on rising edge
// - rst                   in   1      synchronous, active-high reset
// - p{0,1}_req_i          in   1      address-phase request
// - p{0,1}_gnt_o          out  1      address-phase grant
// - p{0,1}_addr_i         in   AW     address
// - p{0,1}_we_i           in   1      write enable
// - p{0,1}_be_i           in   DW/8   byte enables
// - p{0,1}_wdata_i        in   DW     write data
// - p{0,1}_atop_i         in   6      atomic op
// - p{0,1}_rvalid_o       out  1      response valid
// - p{0,1}_rdata_o        out  DW     response data (= mem_rdata_i, valid only with rvalid)
// - p0_misaligned_i       in   1      first half of misaligned pair (used only with macro)
// - mem_req_o/gnt_i/addr_o/we_o/be_o/wdata_o/atop_o  OBI master address phase
// - mem_rvalid_i          in   1      response valid
// - mem_rdata_i           in   DW     response data
// - busy_o                out  1      FIFO non-empty or mem_req_o high
// - resp_err_o            out  1      sticky: mem_rvalid_i seen with FIFO empty
// BEHAVIOUR
// - Reset: FIFO empty, owner lock clear, rr pointer=p0, resp_err_o=0; all outputs 0.
// - Zero latency, combinational: selected port drives mem_*; mem_gnt_i -> its p*_gnt_o.
// - Unselected port: gnt_o=0.
// - Selection:
//   - lock set -> locked owner;
//   - else one requester -> it;
//   - else both -> port != last granted.
// - Lock: mem_req_o=1 & mem_gnt_i=0 -> owner latched; held until that request is granted.
//   - OBI stability rule: no switching mid address phase.
// - FIFO full: mem_req_o forced 0, all gnt_o=0.
//   - Same-cycle pop does not free a slot for that cycle's grant.
// - Handshake:
//   - mem_req_o & mem_gnt_i -> push owner ID, update rr pointer, clear lock.
//   - mem_rvalid_i -> pop head; assert p[head]_rvalid_o in the same cycle.
// - Push and pop in same cycle (not full): count unchanged.
// - Responses arrive in grant order (OBI in-order); no reordering.
// - rvalid with FIFO empty (e.g. after reset mid-transaction): response dropped,
//   no p*_rvalid_o, resp_err_o set until rst.
// - Requester dropping req before gnt: protocol violation, not handled.
// CONFIGURATION
// - LSU_ARB_MISALIGN_LOCK_EN defined:
//   - p0 granted with p0_misaligned_i=1 -> p0 keeps exclusive ownership until its next grant.
//   - p1 receives no grant during that window (second half of the misaligned pair).
// - Undefined: p0_misaligned_i ignored; plain round-robin, p1 may interleave between halves.
// TESTING
// - T1 p0 only: req addr=0x100 we=0, gnt same cycle, rvalid next cycle rdata=0xDEADBEEF
//   -> p0_rvalid_o=1, p0_rdata_o=0xDEADBEEF, p1_rvalid_o=0.
// - T2 p0,p1 req every cycle, gnt always 1 -> grants alternate p0,p1,p0,p1; rr starts p0.
// - T3 p1 req, mem_gnt_i=0 for 3 cycles while p0 asserts req
//   -> mem_addr_o stays p1 addr; p1 granted 4th cycle; p0 next.
// - T4 MAX_OUTSTANDING=2, 2 grants, no rvalid -> third req gets gnt=0, mem_req_o=0;
//   one rvalid -> grant next cycle.
// - T5 rst mid-transaction, then mem_rvalid_i=1 -> no p*_rvalid_o, resp_err_o=1.
// - T6 with macro: p0 granted with p0_misaligned_i=1, p1 req pending
//   -> next grant to p0 (0x104), then p1; without macro -> p1 first.

Source files
------------

// File: rtl/lsu_obi_arbiter.sv
// Round-robin OBI arbiter sharing the LSU data port between core LSU (p0) and a secondary master
// (p1). Optional macro LSU_ARB_MISALIGN_LOCK_EN keeps p0 exclusive across a misaligned pair.
module lsu_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // p0: core LSU
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  input  logic [5:0]              p0_atop_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p0_misaligned_i,
  // p1: secondary master
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  input  logic [5:0]              p1_atop_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  // shared memory port
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [5:0]              mem_atop_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    resp_err_o
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PtrW-1:0]            wptr_q, rptr_q;
  logic [CntW-1:0]            cnt_q;
  logic                       rr_q;       // port favoured when both request
  logic                       lock_q, lock_id_q, err_q;
  logic                       sel, sel_req, full, empty, hs, pop, head, excl_p0;

`ifdef LSU_ARB_MISALIGN_LOCK_EN
  logic excl_q;
  assign excl_p0 = excl_q;

  // Any p0 grant re-arms or releases exclusivity based on its own misaligned flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      excl_q <= 1'b0;
    end else if (hs && !sel) begin
      excl_q <= p0_misaligned_i;
    end
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = p0_misaligned_i;
  assign excl_p0           = 1'b0;
`endif

  always_comb begin
    sel     = 1'b0;
    sel_req = 1'b0;
    if (lock_q) begin
      sel     = lock_id_q;
      sel_req = lock_id_q ? p1_req_i : p0_req_i;
    end else if (excl_p0) begin
      sel     = 1'b0;
      sel_req = p0_req_i;
    end else if (p0_req_i && p1_req_i) begin
      sel     = rr_q;
      sel_req = 1'b1;
    end else begin
      sel     = p1_req_i;
      sel_req = p0_req_i | p1_req_i;
    end
  end

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign mem_req_o = sel_req & ~full & ~rst;
  assign hs        = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~empty & ~rst;
  assign head      = id_q[rptr_q];

  assign p0_gnt_o    = hs & ~sel;
  assign p1_gnt_o    = hs & sel;
  assign p0_rvalid_o = pop & ~head;
  assign p1_rvalid_o = pop & head;
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;
  assign busy_o      = ~empty | mem_req_o;
  assign resp_err_o  = err_q;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    mem_atop_o  = '0;
    if (mem_req_o) begin
      mem_addr_o  = sel ? p1_addr_i  : p0_addr_i;
      mem_we_o    = sel ? p1_we_i    : p0_we_i;
      mem_be_o    = sel ? p1_be_i    : p0_be_i;
      mem_wdata_o = sel ? p1_wdata_i : p0_wdata_i;
      mem_atop_o  = sel ? p1_atop_i  : p0_atop_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (hs) begin
        id_q[wptr_q] <= sel;
        wptr_q       <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        rr_q         <= ~sel;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      if (hs && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !hs) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Hold the owner across a stalled address phase.
      if (hs) begin
        lock_q <= 1'b0;
      end else if (mem_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (mem_rvalid_i && empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_obi_arbiter.sv
// Scoreboard bench for lsu_obi_arbiter: directed vectors push expected grants/responses,
// a negedge monitor pops and compares them.
module tb_lsu_obi_arbiter;

  logic        clk, rst;
  logic        p0_req, p0_gnt, p0_we, p0_rvalid, p0_mis;
  logic        p1_req, p1_gnt, p1_we, p1_rvalid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [3:0]  p0_be, p1_be, mem_be;
  logic [5:0]  p0_atop, p1_atop, mem_atop;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, busy, resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  bit          exp_gnt_port[$];
  logic [31:0] exp_gnt_addr[$];
  bit          exp_rsp_port[$];
  logic [31:0] exp_rsp_data[$];

  lsu_obi_arbiter #(
    .MAX_OUTSTANDING(2),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .p0_req_i       (p0_req),
    .p0_gnt_o       (p0_gnt),
    .p0_addr_i      (p0_addr),
    .p0_we_i        (p0_we),
    .p0_be_i        (p0_be),
    .p0_wdata_i     (p0_wdata),
    .p0_atop_i      (p0_atop),
    .p0_rvalid_o    (p0_rvalid),
    .p0_rdata_o     (p0_rdata),
    .p0_misaligned_i(p0_mis),
    .p1_req_i       (p1_req),
    .p1_gnt_o       (p1_gnt),
    .p1_addr_i      (p1_addr),
    .p1_we_i        (p1_we),
    .p1_be_i        (p1_be),
    .p1_wdata_i     (p1_wdata),
    .p1_atop_i      (p1_atop),
    .p1_rvalid_o    (p1_rvalid),
    .p1_rdata_o     (p1_rdata),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_wdata_o    (mem_wdata),
    .mem_atop_o     (mem_atop),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .busy_o         (busy),
    .resp_err_o     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; p0_mis = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic exp_gnt(input bit port, input logic [31:0] addr);
    exp_gnt_port.push_back(port);
    exp_gnt_addr.push_back(addr);
  endtask

  task automatic exp_rsp(input bit port, input logic [31:0] data);
    exp_rsp_port.push_back(port);
    exp_rsp_data.push_back(data);
  endtask

  // Reset is entered with a live request to show that outputs stay quiet under reset.
  task automatic do_reset();
    step();
    idle();
    rst = 1; p0_req = 1; p0_addr = 32'h100; mem_gnt = 1;
    #2;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    step();
    idle();
    step();
    rst = 0;
    #2;
    chk("rst_err", {31'b0, resp_err}, 0);
    chk("rst_busy_after", {31'b0, busy}, 0);
  endtask

  // Monitor: compares every grant and every response against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if ((mem_req && mem_gnt) || p0_gnt || p1_gnt) begin
        if (exp_gnt_port.size() == 0) begin
          chk("gnt_unexpected", {30'b0, p1_gnt, p0_gnt}, 0);
        end else begin
          automatic bit          ep = exp_gnt_port.pop_front();
          automatic logic [31:0] ea = exp_gnt_addr.pop_front();
          chk("gnt_port", {30'b0, p1_gnt, p0_gnt}, ep ? 32'd2 : 32'd1);
          chk("gnt_addr", mem_addr, ea);
        end
      end
      if (p0_rvalid || p1_rvalid) begin
        if (exp_rsp_port.size() == 0) begin
          chk("rsp_unexpected", {30'b0, p1_rvalid, p0_rvalid}, 0);
        end else begin
          automatic bit          ep = exp_rsp_port.pop_front();
          automatic logic [31:0] ed = exp_rsp_data.pop_front();
          chk("rsp_port", {30'b0, p1_rvalid, p0_rvalid}, ep ? 32'd2 : 32'd1);
          chk("rsp_data", ep ? p1_rdata : p0_rdata, ed);
        end
      end
    end
  end

  initial begin
    logic [31:0] t2_data [4];
    t2_data[0] = 32'h11; t2_data[1] = 32'h22; t2_data[2] = 32'h33; t2_data[3] = 32'h44;
    rst = 1;
    idle();
    p0_addr = '0; p1_addr = '0; p0_we = 0; p1_we = 0; p0_be = 4'hF; p1_be = 4'hF;
    p0_wdata = 32'hA5A5_0000; p1_wdata = 32'h5A5A_0000; p0_atop = '0; p1_atop = '0;
    do_reset();

    // T1: single p0 read.
    step();
    p0_req = 1; p0_addr = 32'h100; mem_gnt = 1;
    exp_gnt(0, 32'h100);
    exp_rsp(0, 32'hDEADBEEF);
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    idle();

    // T2: both request every cycle, alternation starts at p0.
    do_reset();
    p0_addr = 32'h200; p1_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      step();
      p0_req = (i < 4); p1_req = (i < 4); mem_gnt = (i < 4);
      mem_rvalid = (i > 0); mem_rdata = (i > 0) ? t2_data[i-1] : '0;
      if (i < 4) begin
        exp_gnt(i[0], i[0] ? 32'h300 : 32'h200);
        exp_rsp(i[0], t2_data[i]);
      end
    end
    step();
    idle();

    // T3: p1 stalls three cycles while p0 waits; p1 must hold the bus.
    step();
    p1_req = 1; p1_addr = 32'h300;
    #2;
    chk("t3_addr_c1", mem_addr, 32'h300);
    chk("t3_req_c1", {31'b0, mem_req}, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      p0_req = 1; p0_addr = 32'h200;
      #2;
      chk("t3_addr_lock", mem_addr, 32'h300);
      chk("t3_gnt_lock", {30'b0, p1_gnt, p0_gnt}, 0);
    end
    step();
    mem_gnt = 1;
    exp_gnt(1, 32'h300);
    exp_rsp(1, 32'h55);
    step();
    exp_gnt(0, 32'h200);
    exp_rsp(0, 32'h66);
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'h55;
    step();
    mem_rdata = 32'h66;
    step();
    idle();

    // T4: two outstanding fills the FIFO; a pop frees a slot only next cycle.
    step();
    p0_req = 1; p0_addr = 32'h400; mem_gnt = 1;
    exp_gnt(0, 32'h400); exp_rsp(0, 32'h77);
    step();
    p0_addr = 32'h404;
    exp_gnt(0, 32'h404); exp_rsp(0, 32'h88);
    step();
    p0_addr = 32'h408;
    #2;
    chk("t4_full_req", {31'b0, mem_req}, 0);
    chk("t4_full_gnt", {31'b0, p0_gnt}, 0);
    chk("t4_full_busy", {31'b0, busy}, 1);
    step();
    mem_rvalid = 1; mem_rdata = 32'h77;
    #2;
    chk("t4_pop_no_free", {31'b0, mem_req}, 0);
    step();
    mem_rvalid = 0;
    exp_gnt(0, 32'h408); exp_rsp(0, 32'h99);
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'h88;
    step();
    mem_rdata = 32'h99;
    step();
    idle();

    // T5: reset between grant and response; the stray response must be flagged.
    step();
    p0_req = 1; p0_addr = 32'h500; mem_gnt = 1;
    exp_gnt(0, 32'h500);
    step();
    idle(); rst = 1;
    step();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD;
    #2;
    chk("t5_no_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 0);
    step();
    idle();
    #2;
    chk("t5_err_set", {31'b0, resp_err}, 1);
    step();
    #2;
    chk("t5_err_sticky", {31'b0, resp_err}, 1);

    // T6: misaligned pair from p0 with p1 pending.
    do_reset();
    step();
    p0_req = 1; p0_addr = 32'h100; p0_mis = 1; p1_req = 1; p1_addr = 32'h300; mem_gnt = 1;
    exp_gnt(0, 32'h100); exp_rsp(0, 32'hA1);
    step();
    p0_addr = 32'h104; p0_mis = 0; mem_rvalid = 1; mem_rdata = 32'hA1;
`ifdef LSU_ARB_MISALIGN_LOCK_EN
    exp_gnt(0, 32'h104); exp_rsp(0, 32'hA2);
    #2;
    chk("t6_p1_blocked", {31'b0, p1_gnt}, 0);
    step();
    p0_req = 0; mem_rdata = 32'hA2;
    exp_gnt(1, 32'h300); exp_rsp(1, 32'hA3);
`else
    exp_gnt(1, 32'h300); exp_rsp(1, 32'hA2);
    #2;
    chk("t6_p0_waits", {31'b0, p0_gnt}, 0);
    step();
    p1_req = 0; mem_rdata = 32'hA2;
    exp_gnt(0, 32'h104); exp_rsp(0, 32'hA3);
`endif
    step();
    idle(); mem_rvalid = 1; mem_rdata = 32'hA3;
    step();
    idle();
    step();
    step();
    #2;
    chk("end_busy", {31'b0, busy}, 0);
    chk("gnt_queue_drained", exp_gnt_port.size(), 0);
    chk("rsp_queue_drained", exp_rsp_port.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
